// File: rtl/ll_multi_queue_engine_if.sv
// Command/result handshake bundle for ll_multi_queue_engine.
// slave = engine side, master = command arbiter / result consumer side.
interface ll_multi_queue_engine_if #(
  parameter int KEY_WIDTH = 32,
  parameter int QUEUE_CNT = 8
);
  localparam int Q_WIDTH = $clog2(QUEUE_CNT);

  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic [1:0]           cmd_opcode_i;
  logic [Q_WIDTH-1:0]   cmd_qid_i;
  logic [KEY_WIDTH-1:0] cmd_key_i;
  logic                 res_valid_o;
  logic                 res_ready_i;
  logic [1:0]           res_opcode_o;
  logic [Q_WIDTH-1:0]   res_qid_o;
  logic [KEY_WIDTH-1:0] res_key_o;
  logic [1:0]           res_rescode_o;

  modport slave (
    input  cmd_valid_i, cmd_opcode_i, cmd_qid_i, cmd_key_i, res_ready_i,
    output cmd_ready_o, res_valid_o, res_opcode_o, res_qid_o, res_key_o, res_rescode_o
  );

  modport master (
    output cmd_valid_i, cmd_opcode_i, cmd_qid_i, cmd_key_i, res_ready_i,
    input  cmd_ready_o, res_valid_o, res_opcode_o, res_qid_o, res_key_o, res_rescode_o
  );
endinterface

// File: rtl/ll_multi_queue_engine.sv
// ll_multi_queue_engine: QUEUE_CNT FIFO queues of keys sharing one DEPTH-node pool.
// Nodes come from a bump allocator until it saturates, then from a free list threaded
// through the next-pointer RAM. One command in flight; ops ENQ / DEQ / PEEK.
// Optional feature: define LL_MQ_OCCUPANCY_EN to expose per-queue counts on occ_o.
module ll_multi_queue_engine #(
  parameter  int KEY_WIDTH   = 32,
  parameter  int DEPTH       = 256,
  parameter  int QUEUE_CNT   = 8,
  parameter  int RAM_LATENCY = 2,
  localparam int A_WIDTH     = $clog2(DEPTH),
  localparam int Q_WIDTH     = $clog2(QUEUE_CNT),
  localparam int CW          = A_WIDTH + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  ll_multi_queue_engine_if.slave      bus,
  output logic [CW-1:0]               free_cnt_o
`ifdef LL_MQ_OCCUPANCY_EN
  ,
  output logic [QUEUE_CNT*CW-1:0]     occ_o
`endif
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ALLOC_RD = 3'd1;
  localparam logic [2:0] S_HEAD_RD  = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  localparam logic [1:0] OP_ENQ  = 2'd0;
  localparam logic [1:0] OP_DEQ  = 2'd1;
  localparam logic [1:0] OP_PEEK = 2'd2;

  localparam logic [1:0] RC_OK    = 2'd0;
  localparam logic [1:0] RC_EMPTY = 2'd1;
  localparam logic [1:0] RC_FULL  = 2'd2;
  localparam logic [1:0] RC_BADOP = 2'd3;

  localparam int            WW    = (RAM_LATENCY > 1) ? 2 : 1;
  localparam logic [WW-1:0] WLAST = WW'(RAM_LATENCY - 1);
  localparam logic [Q_WIDTH:0] QCNT = (Q_WIDTH+1)'(QUEUE_CNT);
  localparam logic [CW-1:0]    DCNT = CW'(DEPTH);

  // control / command capture
  logic [2:0]           r_state, w_state_nxt;
  logic                 r_ready;
  logic [WW-1:0]        r_wait;
  logic [1:0]           r_op;
  logic [Q_WIDTH-1:0]   r_qid;
  logic [KEY_WIDTH-1:0] r_key;
  logic                 r_from_free;

  // pool and per-queue state
  logic [CW-1:0]        r_bump;
  logic [CW-1:0]        r_free_cnt;
  logic [A_WIDTH-1:0]   r_free_head;
  logic [A_WIDTH-1:0]   r_head [QUEUE_CNT];
  logic [A_WIDTH-1:0]   r_tail [QUEUE_CNT];
  logic [CW-1:0]        r_cnt  [QUEUE_CNT];

  // result registers
  logic                 r_res_valid;
  logic [1:0]           r_res_op;
  logic [Q_WIDTH-1:0]   r_res_qid;
  logic [KEY_WIDTH-1:0] r_res_key;
  logic [1:0]           r_res_code;

  // RAMs and read pipeline
  logic [KEY_WIDTH-1:0] r_key_mem  [DEPTH];
  logic [A_WIDTH-1:0]   r_next_mem [DEPTH];
  logic [KEY_WIDTH-1:0] r_key_rd1;
  logic [A_WIDTH-1:0]   r_next_rd1;
  logic [KEY_WIDTH-1:0] w_rd_key;
  logic [A_WIDTH-1:0]   w_rd_next;

  logic                 w_accept, w_qid_bad, w_bump_ok, w_err;
  logic [1:0]           w_err_code;
  logic [Q_WIDTH-1:0]   w_qidx;
  logic                 w_rd_en;
  logic [A_WIDTH-1:0]   w_rd_addr;
  logic [A_WIDTH-1:0]   w_node;
  logic                 w_key_we, w_next_we;
  logic [A_WIDTH-1:0]   w_next_waddr, w_next_wdata;

  assign w_accept  = bus.cmd_valid_i && r_ready;
  assign w_qid_bad = {1'b0, bus.cmd_qid_i} >= QCNT;
  // keep array indexing in range when a non-power-of-2 count leaves holes
  assign w_qidx    = w_qid_bad ? '0 : bus.cmd_qid_i;
  assign w_bump_ok = r_bump < DCNT;

  // classify the incoming command: anything caught here skips the datapath entirely
  always_comb begin
    w_err      = 1'b0;
    w_err_code = RC_OK;
    if (bus.cmd_opcode_i == 2'd3 || w_qid_bad) begin
      w_err      = 1'b1;
      w_err_code = RC_BADOP;
    end else if (bus.cmd_opcode_i == OP_ENQ) begin
      if (r_free_cnt == '0) begin
        w_err      = 1'b1;
        w_err_code = RC_FULL;
      end
    end else if (r_cnt[w_qidx] == '0) begin
      w_err      = 1'b1;
      w_err_code = RC_EMPTY;
    end
  end

  // a RAM read is needed for DEQ/PEEK (head) and for ENQ once the bump allocator is spent
  assign w_rd_en   = w_accept && !w_err && (bus.cmd_opcode_i != OP_ENQ || !w_bump_ok);
  assign w_rd_addr = (bus.cmd_opcode_i == OP_ENQ) ? r_free_head : r_head[w_qidx];

  assign w_node       = r_from_free ? r_free_head : r_bump[A_WIDTH-1:0];
  assign w_key_we     = (r_state == S_EXEC) && (r_op == OP_ENQ);
  assign w_next_we    = (r_state == S_EXEC) &&
                        ((r_op == OP_ENQ && r_cnt[r_qid] != '0) || r_op == OP_DEQ);
  assign w_next_waddr = (r_op == OP_ENQ) ? r_tail[r_qid] : r_head[r_qid];
  assign w_next_wdata = (r_op == OP_ENQ) ? w_node : r_free_head;

  // RAM write ports and first read stage; reads only happen in IDLE, writes only in EXEC
  always_ff @(posedge clk_i) begin
    if (w_key_we)  r_key_mem[w_node]        <= r_key;
    if (w_next_we) r_next_mem[w_next_waddr] <= w_next_wdata;
    if (w_rd_en) begin
      r_key_rd1  <= r_key_mem[w_rd_addr];
      r_next_rd1 <= r_next_mem[w_rd_addr];
    end
  end

  generate
    if (RAM_LATENCY > 1) begin : g_rd2
      logic [KEY_WIDTH-1:0] r_key_rd2;
      logic [A_WIDTH-1:0]   r_next_rd2;
      // registered-output stage; holds once stage 1 stops changing
      always_ff @(posedge clk_i) begin
        r_key_rd2  <= r_key_rd1;
        r_next_rd2 <= r_next_rd1;
      end
      assign w_rd_key  = r_key_rd2;
      assign w_rd_next = r_next_rd2;
    end else begin : g_rd1
      assign w_rd_key  = r_key_rd1;
      assign w_rd_next = r_next_rd1;
    end
  endgenerate

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (w_err)                              w_state_nxt = S_RESP;
        else if (bus.cmd_opcode_i != OP_ENQ)    w_state_nxt = S_HEAD_RD;
        else if (w_bump_ok)                     w_state_nxt = S_EXEC;
        else                                    w_state_nxt = S_ALLOC_RD;
      end
      S_ALLOC_RD, S_HEAD_RD: if (r_wait == WLAST) w_state_nxt = S_EXEC;
      S_EXEC:                w_state_nxt = S_RESP;
      S_RESP:                if (bus.res_ready_i) w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  // FSM, command capture, list commit and result registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_wait      <= '0;
      r_op        <= '0;
      r_qid       <= '0;
      r_key       <= '0;
      r_from_free <= 1'b0;
      r_bump      <= '0;
      r_free_cnt  <= DCNT;
      r_free_head <= '0;
      for (int q = 0; q < QUEUE_CNT; q++) begin
        r_head[q] <= '0;
        r_tail[q] <= '0;
        r_cnt[q]  <= '0;
      end
      r_res_valid <= 1'b0;
      r_res_op    <= '0;
      r_res_qid   <= '0;
      r_res_key   <= '0;
      r_res_code  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_IDLE);
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op        <= bus.cmd_opcode_i;
          r_qid       <= bus.cmd_qid_i;
          r_key       <= bus.cmd_key_i;
          r_from_free <= !w_bump_ok;
          r_wait      <= '0;
          if (w_err) begin
            r_res_valid <= 1'b1;
            r_res_op    <= bus.cmd_opcode_i;
            r_res_qid   <= bus.cmd_qid_i;
            r_res_key   <= '0;
            r_res_code  <= w_err_code;
          end
        end
        S_ALLOC_RD, S_HEAD_RD: r_wait <= r_wait + WW'(1);
        S_EXEC: begin
          r_res_valid <= 1'b1;
          r_res_op    <= r_op;
          r_res_qid   <= r_qid;
          r_res_code  <= RC_OK;
          case (r_op)
            OP_ENQ: begin
              if (r_cnt[r_qid] == '0) r_head[r_qid] <= w_node;
              r_tail[r_qid] <= w_node;
              r_cnt[r_qid]  <= r_cnt[r_qid] + CW'(1);
              r_free_cnt    <= r_free_cnt - CW'(1);
              if (r_from_free) r_free_head <= w_rd_next;
              else             r_bump      <= r_bump + CW'(1);
              r_res_key     <= r_key;
            end
            OP_DEQ: begin
              // old head becomes the new free-list head; next[head] was rewritten above
              r_free_head   <= r_head[r_qid];
              r_head[r_qid] <= w_rd_next;
              r_cnt[r_qid]  <= r_cnt[r_qid] - CW'(1);
              r_free_cnt    <= r_free_cnt + CW'(1);
              r_res_key     <= w_rd_key;
            end
            default: r_res_key <= w_rd_key;
          endcase
        end
        S_RESP: if (bus.res_ready_i) r_res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready_o   = r_ready;
  assign bus.res_valid_o   = r_res_valid;
  assign bus.res_opcode_o  = r_res_op;
  assign bus.res_qid_o     = r_res_qid;
  assign bus.res_key_o     = r_res_key;
  assign bus.res_rescode_o = r_res_code;
  assign free_cnt_o        = r_free_cnt;

`ifdef LL_MQ_OCCUPANCY_EN
  generate
    for (genvar q = 0; q < QUEUE_CNT; q++) begin : g_occ
      assign occ_o[q*CW +: CW] = r_cnt[q];
    end
  endgenerate
`endif

endmodule
